// File: rtl/scope_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : scope_capture_ctrl_if
// Desc    : sample-RAM write bus between the capture sequencer and the RAM
// Rev     : 1.0
// ============================================================================
interface scope_capture_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 10
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface
`default_nettype wire

// File: rtl/scope_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : scope_capture_ctrl
// Desc    : circular-buffer capture sequencer with pre/post fill and auto trigger
// Rev     : 1.0
// ============================================================================
module scope_capture_ctrl #(
  parameter int AW      = 10,
  parameter int DW      = 10,
  parameter int AUTO_TO = 4096
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  arm,
  input  wire                  abort,
  input  wire                  smp_en,
  input  wire  [DW-1:0]        smp_data,
  input  wire  [DW-1:0]        trig_level,
  input  wire                  trig_rise,
  input  wire                  auto_mode,
  input  wire  [AW-1:0]        pre_len,
  scope_capture_ctrl_if.master wr,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 done,
  output logic                 forced,
  output logic [AW-1:0]        start_addr
);
  localparam int               c_acw       = $clog2(AUTO_TO + 1);
  localparam logic [c_acw-1:0] c_auto_last = c_acw'(AUTO_TO - 1);
  localparam logic [c_acw-1:0] c_auto_sat  = c_acw'(AUTO_TO);
  localparam logic [AW-1:0]    c_one       = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_ptr, r_pre_len, r_pre_cnt, r_post_cnt, r_start_addr;
  logic [DW-1:0]    r_level, r_prev;
  logic             r_rise, r_prev_valid;
  logic [c_acw-1:0] r_auto_cnt;
  logic             r_wr_en, r_done, r_forced;
  logic [AW-1:0]    r_wr_addr;
  logic [DW-1:0]    r_wr_data;

  logic          w_accept, w_edge, w_auto_hit, w_pre_last;
  logic          w_start, w_fire, w_enter_wait;
  logic [AW-1:0] w_post_len;

  assign busy       = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_accept   = smp_en && busy && !abort;
  assign w_edge     = r_prev_valid &&
                      (r_rise ? ((r_prev < r_level) && (smp_data >= r_level))
                              : ((r_prev > r_level) && (smp_data <= r_level)));
  assign w_auto_hit = auto_mode && (r_auto_cnt == c_auto_last);
  assign w_pre_last = (r_pre_cnt + c_one) == r_pre_len;
  // Frame length minus pre-trigger part minus the trigger sample itself.
  assign w_post_len = ~r_pre_len;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_fire      = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            w_start     = 1'b1;
            w_state_nxt = (pre_len == '0) ? S_WAIT : S_PRE;
          end
        end
        S_PRE: begin
          if (w_accept && w_pre_last) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (w_accept && (w_edge || w_auto_hit)) begin
            w_fire      = 1'b1;
            w_state_nxt = (w_post_len == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (w_accept && (r_post_cnt == c_one)) w_state_nxt = S_DONE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_enter_wait = (w_state_nxt == S_WAIT) && (r_state != S_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_pre_len    <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_start_addr <= '0;
      r_level      <= '0;
      r_prev       <= '0;
      r_rise       <= 1'b0;
      r_prev_valid <= 1'b0;
      r_auto_cnt   <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_done       <= 1'b0;
      r_forced     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (abort) begin
        r_done <= 1'b0;
      end else begin
        if (w_start) begin
          r_ptr        <= '0;
          r_pre_len    <= pre_len;
          r_pre_cnt    <= '0;
          r_level      <= trig_level;
          r_rise       <= trig_rise;
          r_prev_valid <= 1'b0;
          r_done       <= 1'b0;
          r_forced     <= 1'b0;
        end
        if (w_accept) begin
          r_wr_en      <= 1'b1;
          r_wr_addr    <= r_ptr;
          r_wr_data    <= smp_data;
          r_ptr        <= r_ptr + c_one;
          r_prev       <= smp_data;
          r_prev_valid <= 1'b1;
        end
        if (w_accept && (r_state == S_PRE)) r_pre_cnt <= r_pre_cnt + c_one;
        if (w_enter_wait) begin
          r_auto_cnt <= '0;
        end else if (w_accept && (r_state == S_WAIT) && (r_auto_cnt != c_auto_sat)) begin
          r_auto_cnt <= r_auto_cnt + 1'b1;
        end
        if (w_fire) begin
          r_start_addr <= r_ptr - r_pre_len;
          r_post_cnt   <= w_post_len;
          r_forced     <= !w_edge;
        end
        if (w_accept && (r_state == S_POST)) r_post_cnt <= r_post_cnt - c_one;
        if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) r_done <= 1'b1;
      end
    end
  end

  assign state      = r_state;
  assign done       = r_done;
  assign forced     = r_forced;
  assign start_addr = r_start_addr;
  assign wr.wr_en   = r_wr_en;
  assign wr.wr_addr = r_wr_addr;
  assign wr.wr_data = r_wr_data;
endmodule
`default_nettype wire

// File: tb/tb_scope_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_scope_capture_ctrl
// Desc    : directed self-checking bench for scope_capture_ctrl (AW=4, AUTO_TO=8)
// Rev     : 1.0
// ============================================================================
module tb_scope_capture_ctrl;
  localparam int AW = 4;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0, abort = 1'b0, smp_en = 1'b0;
  logic [DW-1:0] smp_data = '0, trig_level = '0;
  logic          trig_rise = 1'b1, auto_mode = 1'b0;
  logic [AW-1:0] pre_len = '0;
  logic [2:0]    state;
  logic          busy, done, forced;
  logic [AW-1:0] start_addr;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;
  int base;

  scope_capture_ctrl_if #(.AW(AW), .DW(DW)) wr_if ();

  scope_capture_ctrl #(.AW(AW), .DW(DW), .AUTO_TO(8)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .smp_en(smp_en),
    .smp_data(smp_data), .trig_level(trig_level), .trig_rise(trig_rise),
    .auto_mode(auto_mode), .pre_len(pre_len), .wr(wr_if), .state(state),
    .busy(busy), .done(done), .forced(forced), .start_addr(start_addr)
  );

  always #5 clk = ~clk;

  // Each write pulse is one clock wide, so one sample per falling edge counts it once.
  always @(negedge clk) if (wr_if.wr_en) n_wr <= n_wr + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    smp_en   = 1'b1;
    smp_data = DW'(d);
    tick();
    smp_en   = 1'b0;
  endtask

  task automatic do_arm(input int lvl, input logic rise, input int pl);
    trig_level = DW'(lvl);
    trig_rise  = rise;
    pre_len    = AW'(pl);
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset values
    tick(); tick();
    check("rst_state", 32'(state), 0);
    check("rst_wr_en", 32'(wr_if.wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_start", 32'(start_addr), 0);
    rst_n = 1'b1;
    tick();

    // ---------------- basic frame; smp_en on the arm clock is dropped
    trig_level = 10'd512; trig_rise = 1'b1; pre_len = 4'd4;
    arm = 1'b1; smp_en = 1'b1; smp_data = 10'd999;
    tick();
    arm = 1'b0; smp_en = 1'b0;
    check("b_arm_state", 32'(state), 1);
    check("b_arm_nowr", 32'(wr_if.wr_en), 0);
    base = n_wr;
    send(100);
    check("b_first_addr", 32'(wr_if.wr_addr), 0);
    check("b_first_data", 32'(wr_if.wr_data), 100);
    for (int i = 0; i < 3; i++) send(100);
    check("b_pre_done_state", 32'(state), 2);
    send(100); send(100);
    check("b_wait_state", 32'(state), 2);
    send(600);
    check("b_trig_addr", 32'(wr_if.wr_addr), 6);
    check("b_trig_state", 32'(state), 3);
    check("b_start", 32'(start_addr), 2);
    for (int i = 0; i < 10; i++) send(700);
    check("b_post_state", 32'(state), 3);
    check("b_post_notdone", 32'(done), 0);
    send(700);
    check("b_last_addr", 32'(wr_if.wr_addr), 1);
    check("b_done_state", 32'(state), 4);
    check("b_done", 32'(done), 1);
    check("b_forced", 32'(forced), 0);
    tick();
    check("b_wr_count", 32'(n_wr - base), 18);
    check("b_idle_wr_en", 32'(wr_if.wr_en), 0);
    // arm together with abort from DONE
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check("armabort_state", 32'(state), 0);
    check("armabort_done", 32'(done), 0);

    // ---------------- falling edge, arm while busy, abort mid-POST
    do_arm(300, 1'b0, 0);
    check("f_state", 32'(state), 2);
    arm = 1'b1; pre_len = 4'd7;
    send(400);
    arm = 1'b0; pre_len = 4'd0;
    check("busyarm_state", 32'(state), 2);
    check("busyarm_addr", 32'(wr_if.wr_addr), 0);
    send(400);
    check("f_addr1", 32'(wr_if.wr_addr), 1);
    send(250);
    check("f_trig_state", 32'(state), 3);
    check("f_start", 32'(start_addr), 2);
    send(250);
    abort = 1'b1; smp_en = 1'b1; smp_data = 10'd5;
    tick();
    abort = 1'b0; smp_en = 1'b0;
    check("abort_state", 32'(state), 0);
    check("abort_wr_en", 32'(wr_if.wr_en), 0);
    tick();
    check("abort_wr_en2", 32'(wr_if.wr_en), 0);

    // ---------------- falling: sample equal to level after 301 triggers
    do_arm(300, 1'b0, 0);
    send(301);
    check("feq_no_trig", 32'(state), 2);
    send(300);
    check("feq_trig", 32'(state), 3);
    check("feq_start", 32'(start_addr), 1);
    do_abort();

    // ---------------- first sample above level after arm does not trigger
    do_arm(512, 1'b1, 0);
    send(600);
    check("pv_first", 32'(state), 2);
    send(100);
    send(512);
    check("pv_trig", 32'(state), 3);
    check("pv_start", 32'(start_addr), 2);
    do_abort();

    // ---------------- level crossing inside PRE is ignored
    do_arm(512, 1'b1, 3);
    check("pc_state", 32'(state), 1);
    send(100); send(600);
    check("pc_cross_pre", 32'(state), 1);
    send(100);
    check("pc_to_wait", 32'(state), 2);
    send(600);
    check("pc_trig", 32'(state), 3);
    check("pc_start", 32'(start_addr), 0);
    do_abort();

    // ---------------- auto mode forces on the 8th sample
    auto_mode = 1'b1;
    do_arm(512, 1'b1, 0);
    for (int i = 0; i < 7; i++) send(100);
    check("au_wait", 32'(state), 2);
    tick();
    base = n_wr;
    send(100);
    check("au_trig_addr", 32'(wr_if.wr_addr), 7);
    check("au_trig_state", 32'(state), 3);
    check("au_start", 32'(start_addr), 7);
    for (int i = 0; i < 15; i++) send(100);
    check("au_done", 32'(done), 1);
    check("au_forced", 32'(forced), 1);
    check("au_last_addr", 32'(wr_if.wr_addr), 6);
    tick();
    check("au_wr_count", 32'(n_wr - base), 16);
    // re-arm from DONE with auto off: flags clear and no forced trigger
    auto_mode = 1'b0;
    do_arm(512, 1'b1, 0);
    check("rearm_done", 32'(done), 0);
    check("rearm_forced", 32'(forced), 0);
    for (int i = 0; i < 20; i++) send(100);
    check("noauto_state", 32'(state), 2);
    check("noauto_done", 32'(done), 0);
    do_abort();

    // ---------------- pre_len = 15: DONE straight from the trigger sample
    do_arm(512, 1'b1, 15);
    for (int i = 0; i < 14; i++) send(100);
    check("p15_pre", 32'(state), 1);
    send(100);
    check("p15_wait", 32'(state), 2);
    send(600);
    check("p15_state", 32'(state), 4);
    check("p15_done", 32'(done), 1);
    check("p15_addr", 32'(wr_if.wr_addr), 15);
    check("p15_start", 32'(start_addr), 0);
    do_abort();

    // ---------------- asynchronous reset in WAIT_TRIG
    do_arm(512, 1'b1, 0);
    send(100); send(101);
    rst_n = 1'b0;
    #1;
    check("ar_state", 32'(state), 0);
    check("ar_wr_en", 32'(wr_if.wr_en), 0);
    check("ar_wr_addr", 32'(wr_if.wr_addr), 0);
    check("ar_wr_data", 32'(wr_if.wr_data), 0);
    check("ar_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_arm(512, 1'b1, 0);
    send(100);
    check("ar_rearm_addr", 32'(wr_if.wr_addr), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
